// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - state encoding and default constants for the RO PUF sequencer
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RUN     = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_COMPARE = 3'd4,
      ST_DONE    = 3'd5
   } puf_state_t;

   localparam int DEF_N_BITS     = 8;
   localparam int DEF_SEL_W      = 5;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_WIN_W      = 16;
   localparam int DEF_CLR_CYC    = 2;
   localparam int DEF_SETTLE_CYC = 4;

endpackage

// File: rtl/puf_phase_timer.sv
// rtl/puf_phase_timer.sv - loadable down-counter timing one sequencer phase
// A load of N gives a tc_o pulse in the Nth cycle after the load edge.
module puf_phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ro_puf_sequencer.sv
// rtl/ro_puf_sequencer.sv - sequences RO pair select, clear, run, settle and compare per response bit
// rst_n is active-high; the name is kept for compatibility with the host wrapper.
module ro_puf_sequencer
   import ro_puf_pkg::*;
#(
   parameter int N_BITS     = DEF_N_BITS,
   parameter int SEL_W      = DEF_SEL_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int WIN_W      = DEF_WIN_W,
   parameter int CLR_CYC    = DEF_CLR_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [SEL_W-1:0]            base_sel,
   input  logic [WIN_W-1:0]            win_cycles,
   output logic                        busy,
   output logic                        done,
   output logic [N_BITS-1:0]           response,
   output logic [$clog2(N_BITS+1)-1:0] tie_cnt,
   output logic                        sat_flag,
   output logic [SEL_W-1:0]            sel_a,
   output logic [SEL_W-1:0]            sel_b,
   output logic                        ro_ena,
   output logic                        cnt_clr,
   input  logic [CNT_W-1:0]            cnt_a,
   input  logic [CNT_W-1:0]            cnt_b
);

   localparam int K_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int TIE_W = $clog2(N_BITS + 1);
   localparam logic [K_W-1:0]   K_LAST  = K_W'(N_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   puf_state_t         state_q;
   logic [SEL_W-1:0]   base_q;
   logic [WIN_W-1:0]   win_q;
   logic [K_W-1:0]     k_q;
   logic               busy_q;
   logic               done_q;
   logic [N_BITS-1:0]  resp_q;
   logic [TIE_W-1:0]   tie_q;
   logic               sat_q;
   logic [SEL_W-1:0]   sel_a_q;
   logic [SEL_W-1:0]   sel_b_q;
   logic               ro_ena_q;
   logic               cnt_clr_q;

   logic               tmr_load_d;
   logic [WIN_W-1:0]   tmr_val_d;
   logic               tmr_tc;
   logic [K_W-1:0]     k_d;
   logic [SEL_W-1:0]   sel_a_d;

   // Oscillator A of bit k sits at base+2k, B right after it; both wrap modulo 2**SEL_W.
   function automatic logic [SEL_W-1:0] pair_sel(input logic [SEL_W-1:0] b,
                                                 input logic [K_W-1:0]   k);
      return b + SEL_W'({k, 1'b0});
   endfunction

   assign k_d     = k_q + K_W'(1);
   assign sel_a_d = pair_sel(base_q, k_d);

   // The timer is reloaded on the edge that enters each timed phase.
   always_comb begin
      tmr_load_d = 1'b0;
      tmr_val_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = WIN_W'(CLR_CYC);
            end
         end
         ST_CLEAR: begin
            if (tmr_tc) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = win_q;
            end
         end
         ST_RUN: begin
            if (tmr_tc) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = WIN_W'(SETTLE_CYC);
            end
         end
         ST_COMPARE: begin
            if (k_q != K_LAST) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = WIN_W'(CLR_CYC);
            end
         end
         default: begin
            tmr_load_d = 1'b0;
         end
      endcase
   end

   puf_phase_timer #(
      .CNT_W (WIN_W)
   ) u_phase_timer (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .load_i     (tmr_load_d),
      .load_val_i (tmr_val_d),
      .tc_o       (tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         win_q     <= '0;
         k_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         resp_q    <= '0;
         tie_q     <= '0;
         sat_q     <= 1'b0;
         sel_a_q   <= '0;
         sel_b_q   <= '0;
         ro_ena_q  <= 1'b0;
         cnt_clr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  base_q    <= base_sel;
                  win_q     <= (win_cycles == '0) ? WIN_W'(1) : win_cycles;
                  k_q       <= '0;
                  resp_q    <= '0;
                  tie_q     <= '0;
                  sat_q     <= 1'b0;
                  sel_a_q   <= base_sel;
                  sel_b_q   <= base_sel + SEL_W'(1);
                  busy_q    <= 1'b1;
                  cnt_clr_q <= 1'b1;
                  state_q   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (tmr_tc) begin
                  cnt_clr_q <= 1'b0;
                  ro_ena_q  <= 1'b1;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (tmr_tc) begin
                  ro_ena_q <= 1'b0;
                  state_q  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (tmr_tc) begin
                  state_q <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               // A tie leaves the bit at 0 and is only reported through tie_cnt.
               resp_q[k_q] <= (cnt_a > cnt_b);
               if (cnt_a == cnt_b) begin
                  tie_q <= tie_q + TIE_W'(1);
               end
               if ((cnt_a == CNT_MAX) || (cnt_b == CNT_MAX)) begin
                  sat_q <= 1'b1;
               end
               if (k_q == K_LAST) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  k_q       <= k_d;
                  sel_a_q   <= sel_a_d;
                  sel_b_q   <= sel_a_d + SEL_W'(1);
                  cnt_clr_q <= 1'b1;
                  state_q   <= ST_CLEAR;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign response = resp_q;
   assign tie_cnt  = tie_q;
   assign sat_flag = sat_q;
   assign sel_a    = sel_a_q;
   assign sel_b    = sel_b_q;
   assign ro_ena   = ro_ena_q;
   assign cnt_clr  = cnt_clr_q;

endmodule
